// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the 9-bit-ISA core control path:
// sequencer states, program-counter operations and sizing limits.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    MEM_WAIT,
    HALT
  } seq_state_t;

  typedef enum logic [1:0] {
    PC_HOLD,
    PC_CLEAR,
    PC_INC,
    PC_LOAD
  } pc_op_t;

  localparam int unsigned DEFAULT_PC_W = 10;
  localparam int unsigned MEM_LAT_MAX  = 3;
  localparam int unsigned WAIT_W       = $clog2(MEM_LAT_MAX + 1);

endpackage

// File: rtl/program_counter.sv
// Program counter register: async clear on reset, otherwise hold, clear,
// increment (wrapping) or load an absolute target as selected by the sequencer.
module program_counter
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned PC_W = DEFAULT_PC_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  pc_op_t          op,
  input  logic [PC_W-1:0] load_val,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] pc_q;

  always_comb begin
    pc_d = pc_q;
    unique case (op)
      PC_HOLD:  pc_d = pc_q;
      PC_CLEAR: pc_d = '0;
      PC_INC:   pc_d = pc_q + PC_W'(1);
      PC_LOAD:  pc_d = load_val;
      default:  pc_d = pc_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge inputs; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= '0;
    else        pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: owns pc and run/halt state and gates
// register-file and data-memory strobes so each instruction commits once.
module cpu_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned PC_W    = DEFAULT_PC_W,
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dec_branch_en,
  input  logic             dec_write_en,
  input  logic             dec_mem_read,
  input  logic             dec_mem_write,
  input  logic             dec_done,
  input  logic             branch_taken,
  input  logic [PC_W-1:0]  branch_target,
  output logic [PC_W-1:0]  pc,
  output logic             ex_valid,
  output logic             reg_we,
  output logic             dmem_re,
  output logic             dmem_we,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [WAIT_W-1:0] WAIT_LOAD   = WAIT_W'(MEM_LAT);
  localparam bit                LOAD_STALLS = (MEM_LAT != 0);

  seq_state_t        state_d, state_q;
  logic [WAIT_W-1:0] wait_d, wait_q;
  logic [CNT_W-1:0]  count_d, count_q, count_inc;
  logic              busy_d, busy_q;
  logic              done_d, done_q;
  pc_op_t            pc_op;

  program_counter #(.PC_W(PC_W)) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .op       (pc_op),
    .load_val (branch_target),
    .pc       (pc)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement leaves one unassigned and infers a latch.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    count_d   = count_q;
    pc_op     = PC_HOLD;
    ex_valid  = 1'b0;
    reg_we    = 1'b0;
    dmem_re   = 1'b0;
    dmem_we   = 1'b0;
    count_inc = (count_q == '1) ? count_q : count_q + CNT_W'(1);

    unique case (state_q)
      IDLE, HALT: begin
        if (start) begin
          state_d = RUN;
          pc_op   = PC_CLEAR;
          count_d = '0;
        end
      end
      RUN: begin
        ex_valid = 1'b1;
        if (dec_done) begin
          state_d = HALT;
        end else if (dec_mem_read && LOAD_STALLS) begin
          dmem_re = 1'b1;
          wait_d  = WAIT_LOAD;
          state_d = MEM_WAIT;
        end else begin
          reg_we  = dec_write_en;
          dmem_re = dec_mem_read;
          dmem_we = dec_mem_write & ~dec_mem_read;
          pc_op   = (dec_branch_en && branch_taken) ? PC_LOAD : PC_INC;
          count_d = count_inc;
        end
      end
      MEM_WAIT: begin
        // The load commits on the last wait cycle, ignoring decoder flags.
        dmem_re = 1'b1;
        wait_d  = wait_q - WAIT_W'(1);
        if (wait_q == WAIT_W'(1)) begin
          reg_we  = 1'b1;
          pc_op   = PC_INC;
          count_d = count_inc;
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN) || (state_d == MEM_WAIT);
    done_d = (state_d == HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wait_q  <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer (PC_W=10, MEM_LAT=2, CNT_W=4): each
// driven cycle pushes hand-computed expected outputs; a monitor pops and compares.
module tb_cpu_sequencer;

  localparam int PC_W    = 10;
  localparam int MEM_LAT = 2;
  localparam int CNT_W   = 4;

  // Decoder flag bundle: {branch_en, write_en, mem_read, mem_write, done}
  localparam logic [4:0] D_NONE = 5'b00000;
  localparam logic [4:0] D_BR   = 5'b10000;
  localparam logic [4:0] D_WR   = 5'b01000;
  localparam logic [4:0] D_LD   = 5'b00100;
  localparam logic [4:0] D_ST   = 5'b00010;
  localparam logic [4:0] D_HLT  = 5'b00001;

  // Output bundle: {ex_valid, reg_we, dmem_re, dmem_we, busy, done}
  localparam logic [5:0] O_0  = 6'b000000;
  localparam logic [5:0] O_EX = 6'b100000;
  localparam logic [5:0] O_WE = 6'b010000;
  localparam logic [5:0] O_RE = 6'b001000;
  localparam logic [5:0] O_MW = 6'b000100;
  localparam logic [5:0] O_BZ = 6'b000010;
  localparam logic [5:0] O_DN = 6'b000001;

  typedef struct {
    string            name;
    logic [PC_W-1:0]  pc;
    logic [5:0]       outs;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             dec_branch_en = 1'b0;
  logic             dec_write_en = 1'b0;
  logic             dec_mem_read = 1'b0;
  logic             dec_mem_write = 1'b0;
  logic             dec_done = 1'b0;
  logic             branch_taken = 1'b0;
  logic [PC_W-1:0]  branch_target = '0;
  logic [PC_W-1:0]  pc;
  logic             ex_valid, reg_we, dmem_re, dmem_we, busy, done;
  logic [CNT_W-1:0] instr_count;

  exp_t sb[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  cpu_sequencer #(.PC_W(PC_W), .MEM_LAT(MEM_LAT), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .dec_branch_en (dec_branch_en),
    .dec_write_en  (dec_write_en),
    .dec_mem_read  (dec_mem_read),
    .dec_mem_write (dec_mem_write),
    .dec_done      (dec_done),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc            (pc),
    .ex_valid      (ex_valid),
    .reg_we        (reg_we),
    .dmem_re       (dmem_re),
    .dmem_we       (dmem_we),
    .busy          (busy),
    .done          (done),
    .instr_count   (instr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [PC_W-1:0] e_pc,
                       input logic [5:0] e_o, input logic [CNT_W-1:0] e_cnt);
    logic [5:0] a_o;
    a_o = {ex_valid, reg_we, dmem_re, dmem_we, busy, done};
    tests_run++;
    if (pc !== e_pc || a_o !== e_o || instr_count !== e_cnt) begin
      tests_failed++;
      $display("FAIL %s: got pc=%h outs=%b cnt=%0d, expected pc=%h outs=%b cnt=%0d",
               name, pc, a_o, instr_count, e_pc, e_o, e_cnt);
    end
  endtask

  // One clock cycle of stimulus plus the outputs expected mid-cycle.
  task automatic cyc(input string name, input logic rst, input logic st,
                     input logic [4:0] dec, input logic tk, input logic [PC_W-1:0] tgt,
                     input logic [PC_W-1:0] e_pc, input logic [5:0] e_o,
                     input logic [CNT_W-1:0] e_cnt);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst;
    start = st;
    {dec_branch_en, dec_write_en, dec_mem_read, dec_mem_write, dec_done} = dec;
    branch_taken  = tk;
    branch_target = tgt;
    e.name = name;
    e.pc   = e_pc;
    e.outs = e_o;
    e.cnt  = e_cnt;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check(e.name, e.pc, e.outs, e.cnt);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    cyc("reset",          0, 0, D_NONE,      0, 10'h000, 10'h000, O_0,                0);
    cyc("idle",           1, 0, D_NONE,      0, 10'h000, 10'h000, O_0,                0);
    cyc("start_idle",     1, 1, D_NONE,      0, 10'h000, 10'h000, O_0,                0);
    cyc("alu0",           1, 0, D_WR,        0, 10'h000, 10'h000, O_EX|O_WE|O_BZ,     0);
    cyc("alu1",           1, 0, D_WR,        0, 10'h000, 10'h001, O_EX|O_WE|O_BZ,     1);
    cyc("alu2",           1, 0, D_WR,        0, 10'h000, 10'h002, O_EX|O_WE|O_BZ,     2);
    cyc("halt_instr",     1, 0, D_HLT,       0, 10'h000, 10'h003, O_EX|O_BZ,          3);
    cyc("halted",         1, 0, D_NONE,      0, 10'h000, 10'h003, O_DN,               3);
    cyc("halt_junk",      1, 0, D_WR|D_LD|D_ST, 0, 10'h000, 10'h003, O_DN,            3);
    cyc("start_halt",     1, 1, D_NONE,      0, 10'h000, 10'h003, O_DN,               3);
    cyc("restart_nop",    1, 0, D_NONE,      0, 10'h000, 10'h000, O_EX|O_BZ,          0);
    cyc("br_to_5",        1, 0, D_BR,        1, 10'h005, 10'h001, O_EX|O_BZ,          1);
    cyc("br_taken",       1, 0, D_BR,        1, 10'h020, 10'h005, O_EX|O_BZ,          2);
    cyc("br_back_5",      1, 0, D_BR,        1, 10'h005, 10'h020, O_EX|O_BZ,          3);
    cyc("br_not_taken",   1, 0, D_BR,        0, 10'h020, 10'h005, O_EX|O_BZ,          4);
    cyc("start_in_run",   1, 1, D_WR,        0, 10'h000, 10'h006, O_EX|O_WE|O_BZ,     5);
    cyc("br_to_4",        1, 0, D_BR,        1, 10'h004, 10'h007, O_EX|O_BZ,          6);
    cyc("load_issue",     1, 0, D_LD|D_WR,   0, 10'h000, 10'h004, O_EX|O_RE|O_BZ,     7);
    cyc("load_wait2",     1, 1, D_LD|D_WR,   0, 10'h000, 10'h004, O_RE|O_BZ,          7);
    cyc("load_commit",    1, 0, D_ST|D_HLT,  0, 10'h000, 10'h004, O_RE|O_WE|O_BZ,     7);
    cyc("store0",         1, 0, D_ST,        0, 10'h000, 10'h005, O_EX|O_MW|O_BZ,     8);
    cyc("store1",         1, 0, D_ST,        0, 10'h000, 10'h006, O_EX|O_MW|O_BZ,     9);
    cyc("br_to_3ff",      1, 0, D_BR,        1, 10'h3FF, 10'h007, O_EX|O_BZ,          10);
    cyc("pc_wrap",        1, 0, D_WR,        0, 10'h000, 10'h3FF, O_EX|O_WE|O_BZ,     11);
    cyc("after_wrap",     1, 0, D_WR,        0, 10'h000, 10'h000, O_EX|O_WE|O_BZ,     12);
    cyc("cnt13",          1, 0, D_WR,        0, 10'h000, 10'h001, O_EX|O_WE|O_BZ,     13);
    cyc("cnt14",          1, 0, D_WR,        0, 10'h000, 10'h002, O_EX|O_WE|O_BZ,     14);
    cyc("cnt15",          1, 0, D_WR,        0, 10'h000, 10'h003, O_EX|O_WE|O_BZ,     15);
    cyc("cnt_sat0",       1, 0, D_WR,        0, 10'h000, 10'h004, O_EX|O_WE|O_BZ,     15);
    cyc("ld2_issue",      1, 0, D_LD|D_WR,   0, 10'h000, 10'h005, O_EX|O_RE|O_BZ,     15);
    cyc("ld2_wait",       1, 0, D_LD|D_WR,   0, 10'h000, 10'h005, O_RE|O_BZ,          15);
    cyc("rst_in_wait",    0, 0, D_LD|D_WR,   0, 10'h000, 10'h000, O_0,                0);
    cyc("idle_junk",      1, 0, D_LD|D_WR,   0, 10'h000, 10'h000, O_0,                0);
    cyc("start_again",    1, 1, D_NONE,      0, 10'h000, 10'h000, O_0,                0);
    cyc("halt_first",     1, 1, D_HLT|D_WR,  0, 10'h000, 10'h000, O_EX|O_BZ,          0);
    cyc("halted2",        1, 0, D_NONE,      0, 10'h000, 10'h000, O_DN,               0);

    @(posedge clk);
    @(negedge clk);
    #1;
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle instruction sequencer for the 9-bit-ISA core. It owns the program counter and the run/halt state, and consumes the per-instruction control flags from the control decoder. It gates register-file writes and data-memory strobes so that each instruction commits exactly once, including loads that wait on a multi-cycle data memory. It sits between the instruction ROM and decoder (upstream) and the register file, ALU and data memory (downstream).

## Interface
- `PC_W`, 10: program counter width.
- `MEM_LAT`, 1: load wait cycles (0..3); 0 means single-cycle load.
- `CNT_W`, 16: retired-instruction counter width.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin execution at pc=0; sampled only in IDLE/HALT.
- `dec_branch_en`  in  1  decoder: instruction is a branch.
- `dec_write_en`  in  1  decoder: instruction writes a register.
- `dec_mem_read`  in  1  decoder: load.
- `dec_mem_write`  in  1  decoder: store.
- `dec_done`  in  1  decoder: halt instruction.
- `branch_taken`  in  1  ALU condition result for the current branch.
- `branch_target`  in  PC_W  absolute target from the branch LUT.
- `pc`  out  PC_W  address into the instruction ROM.
- `ex_valid`  out  1  instruction at `pc` is in its execute cycle.
- `reg_we`  out  1  register-file write commit.
- `dmem_re`  out  1  data-memory read strobe.
- `dmem_we`  out  1  data-memory write strobe.
- `busy`  out  1  state is RUN or MEM_WAIT.
- `done`  out  1  program halted.
- `instr_count`  out  CNT_W  retired instructions, saturating.

## Operation
States: IDLE, RUN, MEM_WAIT, HALT.

- **IDLE:** pc=0. When `start`=1: clear `instr_count` and go to RUN.
- **RUN:** `ex_valid`=1. Decoder flags are evaluated with priority done > mem_read > everything else.
  - `dec_done`: go to HALT. No strobes, pc held, count not incremented.
  - `dec_mem_read` with MEM_LAT>0: `dmem_re`=1, `reg_we`=0, load the wait counter with MEM_LAT, go to MEM_WAIT, pc held.
  - Otherwise the instruction retires this cycle:
    - `reg_we`=`dec_write_en`.
    - `dmem_re`=`dec_mem_read` (MEM_LAT=0 case).
    - `dmem_we`=`dec_mem_write & ~dec_mem_read`.
    - pc ← `branch_target` if `dec_branch_en & branch_taken`, else pc+1.
    - count+1.
- **MEM_WAIT:** `ex_valid`=0 and `dmem_re`=1 throughout; the wait counter decrements each cycle.
  - On the cycle the counter equals 1: `reg_we`=1, pc ← pc+1, count+1, return to RUN.
- **HALT:** `done`=1. `start` clears pc and count and goes to RUN.

Boundary rules:
- pc+1 at all-ones wraps to 0.
- `instr_count` saturates at all-ones.
- `start` in RUN or MEM_WAIT is ignored.
- A not-taken branch behaves as a plain pc+1 instruction.
- Any decoder inputs in IDLE, MEM_WAIT or HALT other than the documented ones produce no strobes.
- `rst_n` low at any time, including mid-MEM_WAIT, immediately forces IDLE, pc=0, count=0 and all outputs 0. No partial commit occurs.

## Timing
- Reset values: pc=0, instr_count=0, done=0, busy=0, ex_valid=0, reg_we=0, dmem_re=0, dmem_we=0, state IDLE.
- Registered outputs: `pc`, `done`, `busy`, `instr_count`.
- Combinational outputs, decoded from state, decoder inputs and the wait counter: `ex_valid`, `reg_we`, `dmem_re`, `dmem_we`.
- `start` high at edge N: at N+1 state is RUN, pc=0, busy=1.
- Non-load instruction: 1 cycle. Load: 1+MEM_LAT cycles.
- Halting instruction seen at edge N: `done`=1 and `busy`=0 from N+1.
- A branch target is visible on `pc` one cycle after the branch's execute cycle.

## Structure
- Shared package `cpu_ctrl_pkg`:
  - enum `seq_state_t` {IDLE, RUN, MEM_WAIT, HALT};
  - default PC width constant;
  - MEM_LAT upper bound (3).
- One sub-module, `program_counter`: a PC_W-bit register with async active-low clear plus synchronous clear, hold, increment and load operations, selected by a 2-bit op from the FSM.
- Wait counter and retire counter live in `cpu_sequencer`.

## Test plan
- Reset then `start` pulse, decoder reports three ALU ops then done → pc 0,1,2,3 then held at 3; done=1 on the 5th cycle after start; instr_count=3; reg_we high for exactly 3 cycles.
- Branch at pc=5, `branch_taken`=1, target=0x020 → pc=0x020 next cycle. Repeat with `branch_taken`=0 → pc=6.
- MEM_LAT=2, load at pc=4 → dmem_re high 3 cycles, reg_we only on the third, pc=5 after; store → dmem_we 1 cycle, reg_we=0.
- pc=0x3FF with a non-branch instruction → pc wraps to 0x000. CNT_W=4 with 20 instructions → instr_count holds at 15.
- `rst_n` asserted during MEM_WAIT → next sample shows IDLE with all outputs 0, no reg_we pulse. `start` during RUN → ignored, pc sequence unchanged.
- `start` in HALT → pc=0, count=0, done=0, busy=1 on the next cycle.
